instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage directly downstream of the program counter. It reads a 16-entry instruction memory at the PC's 4-bit instruction address and registers the result into an instruction register (IR). The IR is presented to the decode stage with a valid/ready handshake. The block also issues the one-cycle PC_enable pulse that advances the program counter once the decoder has accepted an instruction.

Parameters:
INSTR_WIDTH, 16, instruction word width in bits
ADDR_WIDTH, 4, instruction address width; matches the PC output
DEPTH, 16, instruction memory entries (2**ADDR_WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
fetch_en  input  1  run enable; low = stop fetching
instruction_addr  input  ADDR_WIDTH  current PC value from program counter
prog_we  input  1  instruction memory write strobe
prog_addr  input  ADDR_WIDTH  memory write address
prog_data  input  INSTR_WIDTH  memory write data
flush  input  1  discard IR contents and refetch at current instruction_addr
ir_ready  input  1  decode stage can accept IR
ir_data  output  INSTR_WIDTH  registered instruction word
ir_pc  output  ADDR_WIDTH  address ir_data was fetched from
ir_valid  output  1  ir_data/ir_pc valid
pc_enable  output  1  one-cycle pulse to the PC's PC_enable
instr_count  output  8  count of accepted instructions

Behaviour:
- Reset is asynchronous: state=IDLE; ir_data=0, ir_pc=0, ir_valid=0, pc_enable=0, instr_count=0. Memory contents are not reset.
- Memory:
  - Synchronous write when prog_we=1, in any state.
  - A read of the address being written in the same cycle returns the old data.
- All outputs are registered.
- FSM states: IDLE, FETCH, VALID, ADVANCE.
  - IDLE: outputs hold (ir_valid=0, pc_enable=0). If fetch_en=1, go to FETCH.
  - FETCH: if fetch_en=0, go to IDLE with no capture. Otherwise, at the edge: ir_data<=mem[instruction_addr], ir_pc<=instruction_addr, ir_valid<=1, go to VALID.
    - Fetch latency is 1 cycle from entering FETCH to ir_valid=1.
  - VALID: ir_data and ir_pc are held stable while ir_valid=1 and ir_ready=0.
    - If ir_ready=1 at the edge: ir_valid<=0, pc_enable<=1, instr_count<=instr_count+1, go to ADVANCE.
    - fetch_en=0 in VALID does not drop the IR; the instruction is held until accepted.
  - ADVANCE: pc_enable=1 for exactly this cycle; the PC updates at the end of this cycle.
    - The decoder must hold jump/jump_label/pc_increment valid during ADVANCE.
    - At the edge: pc_enable<=0; go to FETCH if fetch_en=1, else IDLE.
- Issue rate is one instruction per 3 cycles at full rate (FETCH, VALID, ADVANCE). The IR never loads from a stale PC, because FETCH always follows the PC update.
- flush has priority over everything except rst. At the edge: ir_valid<=0, pc_enable<=0, instr_count unchanged, go to FETCH if fetch_en=1, else IDLE.
  - A flush in VALID with ir_ready=1 suppresses the acceptance: no count and no pc_enable.
  - A flush in ADVANCE cancels the pulse at that edge. The pulse already asserted in that cycle still counts for the PC.
- instr_count wraps from 255 to 0.
- Address width follows ADDR_WIDTH; there is no out-of-range case with DEPTH=2**ADDR_WIDTH.
- Reset mid-operation: all outputs clear immediately (asynchronous), and any in-flight pc_enable pulse is cut.

Test Plan:
- Preload mem[0]=16'hA001 and mem[1]=16'hB002, instruction_addr=0, fetch_en=1, ir_ready=1 -> ir_valid rises 1 cycle after FETCH with ir_data=A001, ir_pc=0. pc_enable pulses exactly 1 cycle. After the bench PC moves to 1, ir_data=B002, and instr_count=2 after 6 cycles.
- Backpressure: ir_ready=0 for 5 cycles in VALID -> ir_data and ir_pc stable, pc_enable=0 throughout. Raising ir_ready -> a single pc_enable pulse on the next cycle and instr_count+1.
- flush asserted in VALID with ir_ready=1 -> ir_valid=0 next cycle, no pc_enable, instr_count unchanged. The IR is refetched from the same instruction_addr.
- fetch_en dropped in VALID -> instruction held until accepted, then ADVANCE, then IDLE with ir_valid=0. Dropping fetch_en in FETCH -> IDLE with no capture.
- prog_we to address 3 with data 16'hC0DE while instruction_addr=3 in FETCH -> IR captures the old mem[3]. The next fetch of address 3 returns C0DE.
- Assert rst while in ADVANCE -> pc_enable, ir_valid and instr_count are 0 immediately. Memory retains its data; the next fetch of address 0 returns A001.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode bus: memory programming port, PC input, IR handshake and PC advance pulse.
interface instruction_fetch_unit_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 4
);
    logic                   fetch_en;
    logic [ADDR_WIDTH-1:0]  instruction_addr;
    logic                   prog_we;
    logic [ADDR_WIDTH-1:0]  prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   flush;
    logic                   ir_ready;
    logic [INSTR_WIDTH-1:0] ir_data;
    logic [ADDR_WIDTH-1:0]  ir_pc;
    logic                   ir_valid;
    logic                   pc_enable;
    logic [7:0]             instr_count;

    modport master (
        output fetch_en, instruction_addr, prog_we, prog_addr, prog_data, flush, ir_ready,
        input  ir_data, ir_pc, ir_valid, pc_enable, instr_count
    );

    modport slave (
        input  fetch_en, instruction_addr, prog_we, prog_addr, prog_data, flush, ir_ready,
        output ir_data, ir_pc, ir_valid, pc_enable, instr_count
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads instruction memory at the PC, holds the word in the IR until decode
// accepts it, then pulses pc_enable for one cycle so the PC advances.
module instruction_fetch_unit #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    instruction_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        VALID   = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0] r_ir_data;
    logic [ADDR_WIDTH-1:0]  r_ir_pc;
    logic                   r_ir_valid;
    logic                   r_pc_enable;
    logic [7:0]             r_instr_count;

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Fetch FSM; the IR read samples r_mem before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ir_data     <= {INSTR_WIDTH{1'b0}};
            r_ir_pc       <= {ADDR_WIDTH{1'b0}};
            r_ir_valid    <= 1'b0;
            r_pc_enable   <= 1'b0;
            r_instr_count <= 8'd0;
        end else if (bus.flush) begin
            r_ir_valid  <= 1'b0;
            r_pc_enable <= 1'b0;
            r_state     <= bus.fetch_en ? FETCH : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ir_valid  <= 1'b0;
                    r_pc_enable <= 1'b0;
                    if (bus.fetch_en) begin
                        r_state <= FETCH;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FETCH: begin
                    r_pc_enable <= 1'b0;
                    if (bus.fetch_en) begin
                        r_ir_data  <= r_mem[bus.instruction_addr];
                        r_ir_pc    <= bus.instruction_addr;
                        r_ir_valid <= 1'b1;
                        r_state    <= VALID;
                    end else begin
                        r_ir_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                VALID: begin
                    // fetch_en is ignored here: a presented instruction is never dropped.
                    if (bus.ir_ready) begin
                        r_ir_valid    <= 1'b0;
                        r_pc_enable   <= 1'b1;
                        r_instr_count <= r_instr_count + 8'd1;
                        r_state       <= ADVANCE;
                    end else begin
                        r_ir_valid  <= 1'b1;
                        r_pc_enable <= 1'b0;
                        r_state     <= VALID;
                    end
                end
                ADVANCE: begin
                    r_ir_valid  <= 1'b0;
                    r_pc_enable <= 1'b0;
                    r_state     <= bus.fetch_en ? FETCH : IDLE;
                end
                default: begin
                    r_ir_valid  <= 1'b0;
                    r_pc_enable <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ir_data     = r_ir_data;
    assign bus.ir_pc       = r_ir_pc;
    assign bus.ir_valid    = r_ir_valid;
    assign bus.pc_enable   = r_pc_enable;
    assign bus.instr_count = r_instr_count;

endmodule
